// File: rtl/fifo.sv
// fifo: synchronous FIFO with registered read data; define FIFO_OVF_FLAG_EN to add a sticky ovf_flag output
module fifo #(
  parameter int SIZE = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] data_in,
  input  logic            valid_write,
  input  logic            valid_read,
  output logic [SIZE-1:0] data_out,
  output logic            f_flag,
  output logic            e_flag,
  output logic            almost_full_flag
`ifdef FIFO_OVF_FLAG_EN
  ,
  output logic            ovf_flag
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic rd, wr;
  always_comb begin
    rd = valid_read && !e_flag;
    wr = valid_write && (!f_flag || rd);
  end
  assign f_flag = count == (AW+1)'(DEPTH);
  assign e_flag = count == '0;
  assign almost_full_flag = count >= (AW+1)'(DEPTH - 1);
  always_ff @(posedge clk)
    if (wr && !rst) mem[wptr] <= data_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      data_out <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) begin
        rptr <= rptr + AW'(1);
        data_out <= mem[rptr];
      end
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
`ifdef FIFO_OVF_FLAG_EN
  always_ff @(posedge clk)
    if (rst) ovf_flag <= 1'b0;
    else if (valid_write && !wr) ovf_flag <= 1'b1;
`endif
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed stimulus for fifo with a queue-based reference model checked every cycle
module tb_fifo;
  logic clk = 1'b0;
  logic rst, valid_write, valid_read;
  logic [7:0] data_in, data_out;
  logic f_flag, e_flag, almost_full_flag;
`ifdef FIFO_OVF_FLAG_EN
  logic ovf_flag;
`endif
  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [7:0] q[$];
  logic [7:0] m_dout = 8'd0;
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  fifo #(.SIZE(8), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .valid_write(valid_write),
    .valid_read(valid_read),
    .data_out(data_out),
    .f_flag(f_flag),
    .e_flag(e_flag),
    .almost_full_flag(almost_full_flag)
`ifdef FIFO_OVF_FLAG_EN
    ,
    .ovf_flag(ovf_flag)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a queue of at most 4 entries, read pops before write pushes
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_dout = 8'd0;
      m_ovf = 1'b0;
    end else begin
      bit rd, full;
      full = q.size() == 4;
      rd = valid_read && q.size() > 0;
      if (rd) m_dout = q.pop_front();
      if (valid_write && (!full || rd)) q.push_back(data_in);
      else if (valid_write) m_ovf = 1'b1;
    end
  end

  always @(negedge clk)
    if (chk_en) begin
      check("model_data_out", 32'(data_out), 32'(m_dout));
      check("model_f_flag", 32'(f_flag), 32'(q.size() == 4));
      check("model_e_flag", 32'(e_flag), 32'(q.size() == 0));
      check("model_almost_full", 32'(almost_full_flag), 32'(q.size() >= 3));
`ifdef FIFO_OVF_FLAG_EN
      check("model_ovf_flag", 32'(ovf_flag), 32'(m_ovf));
`endif
    end

  task automatic cyc(input logic rs, input logic w, input logic r, input logic [7:0] d);
    rst = rs;
    valid_write = w;
    valid_read = r;
    data_in = d;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] fill_v[5];
    logic [7:0] drain_v[5];
    fill_v = '{8'd21, 8'd247, 8'd90, 8'd10, 8'd20};
    drain_v = '{8'd21, 8'd247, 8'd90, 8'd10, 8'd10};
    rst = 1'b1;
    valid_write = 1'b0;
    valid_read = 1'b0;
    data_in = 8'd0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk_en = 1'b1;
    check("reset_data_out", 32'(data_out), 0);
    check("reset_e_flag", 32'(e_flag), 1);
    check("reset_f_flag", 32'(f_flag), 0);
    check("reset_almost_full", 32'(almost_full_flag), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, fill_v[i]);
      check("fill_almost_full", 32'(almost_full_flag), 32'(i >= 2));
      check("fill_f_flag", 32'(f_flag), 32'(i >= 3));
    end
`ifdef FIFO_OVF_FLAG_EN
    check("fill_ovf_flag", 32'(ovf_flag), 1);
`endif
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0);
      check("drain_data_out", 32'(data_out), 32'(drain_v[i]));
      check("drain_e_flag", 32'(e_flag), 32'(i >= 3));
    end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, i > 0, 8'(i));
      if (i > 0) check("wrap_data_out", 32'(data_out), 32'(i - 1));
      check("wrap_f_flag", 32'(f_flag), 0);
    end
    cyc(0, 0, 1, 0);
    check("wrap_last", 32'(data_out), 9);
    check("wrap_e_flag", 32'(e_flag), 1);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'(i));
    check("sim_full_before", 32'(f_flag), 1);
    cyc(0, 1, 1, 8'd4);
    check("sim_data_out", 32'(data_out), 0);
    check("sim_f_flag", 32'(f_flag), 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 1, 0);
      check("sim_read", 32'(data_out), 32'(i));
    end
    check("sim_e_flag", 32'(e_flag), 1);
    cyc(0, 1, 0, 8'd55);
    cyc(0, 1, 0, 8'd66);
    check("mid_two_entries", 32'(e_flag), 0);
    cyc(1, 1, 1, 8'd77);
    check("mid_rst_e_flag", 32'(e_flag), 1);
    check("mid_rst_data_out", 32'(data_out), 0);
    cyc(0, 0, 1, 0);
    check("mid_read_data_out", 32'(data_out), 0);
    check("mid_read_e_flag", 32'(e_flag), 1);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 SHALL have parameter SIZE, default 8: data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4: number of storage entries (power of two, >=4).
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous to clk, active-high.
REQ-005 SHALL have port data_in, input, SIZE: write data.
REQ-006 SHALL have port valid_write, input, 1: write request, sampled at clk rising edge.
REQ-007 SHALL have port valid_read, input, 1: read request, sampled at clk rising edge.
REQ-008 SHALL have port data_out, output, SIZE: registered read data.
REQ-009 SHALL have port f_flag, output, 1: full, count == DEPTH.
REQ-010 SHALL have port e_flag, output, 1: empty, count == 0.
REQ-011 SHALL have port almost_full_flag, output, 1: count >= DEPTH-1.

Function
REQ-012 SHALL store entries in a DEPTH x SIZE array addressed by write and read pointers of width log2(DEPTH), each wrapping modulo DEPTH.
REQ-013 SHALL keep an occupancy count of width log2(DEPTH)+1, range 0..DEPTH.
REQ-014 SHALL accept a write when valid_write=1 and (not full, or full with an accepted read in the same cycle): store data_in at wptr and increment wptr.
REQ-015 SHALL accept a read when valid_read=1 and not empty: load mem[rptr] into data_out at that edge (data visible one cycle after the request) and increment rptr.
REQ-016 SHALL drop a write attempted while full with no accepted read; memory, wptr and count remain unchanged.
REQ-017 SHALL ignore a read attempted while empty; data_out holds its last value. There is no write-to-read bypass: simultaneous read and write when empty accepts only the write.
REQ-018 SHALL update count as +1 (write only), -1 (read only) or unchanged (both accepted, or neither).
REQ-019 SHALL derive f_flag, e_flag and almost_full_flag combinationally from the registered count, so they change in the cycle after the causing edge.
REQ-020 SHALL return data in exact write order across pointer wrap-around.
REQ-021 SHALL have no combinational path from any input to any output.

Reset
REQ-022 SHALL, while rst=1 at a clk edge, set wptr=0, rptr=0, count=0, data_out=0, giving e_flag=1, f_flag=0, almost_full_flag=0.
REQ-023 SHALL give rst priority over simultaneous read/write; reset mid-operation discards all contents. Memory array contents need not be cleared.

Configuration
REQ-024 SHALL, when macro FIFO_OVF_FLAG_EN is defined, add output ovf_flag (1 bit): sticky, set the cycle after a write is dropped per REQ-016, cleared only by rst (reset value 0).
REQ-025 SHALL, without FIFO_OVF_FLAG_EN, have no ovf_flag port and no associated logic; all other behaviour is identical.

Verification (SIZE=8, DEPTH=4)
REQ-026 SHALL check reset: assert rst 2 cycles -> data_out=0, e_flag=1, f_flag=0, almost_full_flag=0.
REQ-027 SHALL check fill/overflow: write 21,247,90,10,20 with no reads -> almost_full_flag=1 after the 3rd write, f_flag=1 after the 4th, 5th write (20) dropped (ovf_flag=1 if enabled).
REQ-028 SHALL check drain: read 5 times after REQ-027 -> data_out 21,247,90,10 then holds 10; e_flag=1 after the 4th read.
REQ-029 SHALL check wrap: write 0..9 interleaved with reads (read active from the 2nd write onward) -> outputs 0..9 in order; f_flag never set.
REQ-030 SHALL check simultaneous access: with FIFO full (0,1,2,3), assert write 4 and read together -> data_out=0, count stays 4, f_flag stays 1; subsequent reads return 1,2,3,4.
REQ-031 SHALL check reset mid-operation: with 2 entries stored, pulse rst -> e_flag=1, data_out=0; a following read returns nothing new.
